// File: rtl/btb_update_queue_if.sv
// Handshake bundle between the branch-resolution side, the update queue and the BTB write port.
// Signal suffixes are relative to the queue: _i flows into it, _o flows out of it.
interface btb_update_queue_if #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [ADDR_WIDTH-1:0] in_pc_i;
    logic [ADDR_WIDTH-1:0] in_target_i;
    logic                  in_taken_i;
    logic                  drain_stall_i;
    logic                  update_valid_o;
    logic [ADDR_WIDTH-1:0] update_pc_o;
    logic [ADDR_WIDTH-1:0] update_branch_target_o;
    logic [CntW-1:0]       count_o;

    modport slave (
        input  in_valid_i, in_pc_i, in_target_i, in_taken_i, drain_stall_i,
        output in_ready_o, update_valid_o, update_pc_o, update_branch_target_o, count_o
    );

    modport master (
        output in_valid_i, in_pc_i, in_target_i, in_taken_i, drain_stall_i,
        input  in_ready_o, update_valid_o, update_pc_o, update_branch_target_o, count_o
    );
endinterface

// File: rtl/btb_update_queue.sv
// Circular queue of resolved taken-branch updates feeding the single BTB write port.
// Updates to a PC already queued overwrite that entry's target in place.
module btb_update_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input logic               clk,
    input logic               rst,
    btb_update_queue_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned TgtW = ADDR_WIDTH - 2;

    logic [PtrW-1:0]       head_q, head_d;
    logic [PtrW-1:0]       tail_q, tail_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [ADDR_WIDTH-1:0] pc_q  [DEPTH];
    logic [TgtW-1:0]       tgt_q [DEPTH];

    logic                  upd_valid_q, upd_valid_d;
    logic [ADDR_WIDTH-1:0] upd_pc_q, upd_pc_d;
    logic [TgtW-1:0]       upd_tgt_q, upd_tgt_d;

    logic                  in_ready;
    logic                  accept;
    logic                  pop;
    logic                  alloc;
    logic                  hit_any;
    logic [DEPTH-1:0]      hit;
    logic [PtrW-1:0]       hit_idx;
    logic                  unused_tgt_lsb;

    assign unused_tgt_lsb = ^bus.in_target_i[1:0];

    // Ready depends on registered occupancy only, never on the incoming request.
    assign in_ready = (count_q < CntW'(DEPTH));
    assign pop      = (count_q != '0) && !bus.drain_stall_i;
    assign accept   = bus.in_valid_i && in_ready && bus.in_taken_i;

    // An entry is live when its distance from head is below count; a head leaving
    // this cycle cannot absorb a new update.
    always_comb begin
        hit     = '0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = ({1'b0, PtrW'(i) - head_q} < count_q)
                     && !(pop && (PtrW'(i) == head_q))
                     && (pc_q[i] == bus.in_pc_i);
            if (hit[i]) begin
                hit_idx = PtrW'(i);
            end
        end
    end

    assign hit_any = |hit;
    assign alloc   = accept && !hit_any;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q + CntW'(alloc) - CntW'(pop);
        upd_valid_d = pop;
        upd_pc_d    = upd_pc_q;
        upd_tgt_d   = upd_tgt_q;
        if (pop) begin
            head_d    = head_q + PtrW'(1);
            upd_pc_d  = pc_q[head_q];
            upd_tgt_d = tgt_q[head_q];
        end
        if (alloc) begin
            tail_d = tail_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            upd_valid_q <= 1'b0;
            upd_pc_q    <= '0;
            upd_tgt_q   <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            upd_valid_q <= upd_valid_d;
            upd_pc_q    <= upd_pc_d;
            upd_tgt_q   <= upd_tgt_d;
        end
    end

    // Entry payload needs no reset; validity is carried by head/count.
    always_ff @(posedge clk) begin
        if (alloc) begin
            pc_q[tail_q]  <= bus.in_pc_i;
            tgt_q[tail_q] <= bus.in_target_i[ADDR_WIDTH-1:2];
        end else if (accept && hit_any) begin
            tgt_q[hit_idx] <= bus.in_target_i[ADDR_WIDTH-1:2];
        end
    end

    assign bus.in_ready_o             = in_ready;
    assign bus.count_o                = count_q;
    assign bus.update_valid_o         = upd_valid_q;
    assign bus.update_pc_o            = upd_pc_q;
    assign bus.update_branch_target_o = {upd_tgt_q, 2'b00};
endmodule

// File: tb/tb_btb_update_queue.sv
// Scoreboard bench for btb_update_queue: expected BTB writes are queued as stimulus is
// driven and matched against each update strobe.
module tb_btb_update_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    btb_update_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) bus ();

    btb_update_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every strobe must match the oldest outstanding expected update.
    always @(negedge clk) begin
        if (rst && bus.update_valid_o) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_strobe", 64'(bus.update_valid_o), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("update_pc", 64'(bus.update_pc_o), 64'(mon_e[63:32]));
                check_eq("update_target", 64'(bus.update_branch_target_o), 64'(mon_e[31:0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        bus.in_valid_i  = 1'b1;
        bus.in_pc_i     = pc;
        bus.in_target_i = tgt;
        bus.in_taken_i  = taken;
        step();
        bus.in_valid_i  = 1'b0;
    endtask

    task automatic expect_upd(input logic [31:0] pc, input logic [31:0] tgt);
        exp_q.push_back({pc, tgt});
    endtask

    task automatic drain(input string tag);
        int unsigned budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 40) begin
            step();
            budget++;
        end
        step();
        step();
        check_eq({tag, "_leftover"}, 64'(exp_q.size()), 64'd0);
        check_eq({tag, "_count"}, 64'(bus.count_o), 64'd0);
    endtask

    initial begin
        bus.in_valid_i    = 1'b1;
        bus.in_pc_i       = 32'hDEAD0000;
        bus.in_target_i   = 32'hBEEF0000;
        bus.in_taken_i    = 1'b1;
        bus.drain_stall_i = 1'b0;

        // Reset held with a request pending
        #1;
        repeat (3) step();
        check_eq("reset_valid", 64'(bus.update_valid_o), 64'd0);
        check_eq("reset_count", 64'(bus.count_o), 64'd0);
        check_eq("reset_ready", 64'(bus.in_ready_o), 64'd1);
        check_eq("reset_pc", 64'(bus.update_pc_o), 64'd0);
        check_eq("reset_target", 64'(bus.update_branch_target_o), 64'd0);
        bus.in_valid_i = 1'b0;
        rst = 1'b1;
        repeat (4) step();
        check_eq("post_reset_valid", 64'(bus.update_valid_o), 64'd0);
        check_eq("post_reset_count", 64'(bus.count_o), 64'd0);

        // Single update: strobe two edges after acceptance
        push(32'h1C000010, 32'h1C000100, 1'b1);
        expect_upd(32'h1C000010, 32'h1C000100);
        check_eq("lat_c1_valid", 64'(bus.update_valid_o), 64'd0);
        check_eq("lat_c1_count", 64'(bus.count_o), 64'd1);
        step();
        check_eq("lat_c2_valid", 64'(bus.update_valid_o), 64'd1);
        check_eq("lat_c2_count", 64'(bus.count_o), 64'd0);
        step();
        check_eq("lat_c3_valid", 64'(bus.update_valid_o), 64'd0);
        drain("single");

        // Not-taken branches are consumed but never stored
        check_eq("nt_ready", 64'(bus.in_ready_o), 64'd1);
        push(32'h1C000020, 32'h1C000200, 1'b0);
        check_eq("nt_count", 64'(bus.count_o), 64'd0);
        repeat (3) step();
        check_eq("nt_valid", 64'(bus.update_valid_o), 64'd0);

        // Fill under stall, reject a fifth, then drain back-to-back
        bus.drain_stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(32'h1C001000 + 32'(16 * i), 32'h1C002000 + 32'(256 * i), 1'b1);
            expect_upd(32'h1C001000 + 32'(16 * i), 32'h1C002000 + 32'(256 * i));
        end
        check_eq("fill_count", 64'(bus.count_o), 64'd4);
        check_eq("fill_ready", 64'(bus.in_ready_o), 64'd0);
        push(32'h1C001100, 32'h1C003000, 1'b1);
        check_eq("fill5_count", 64'(bus.count_o), 64'd4);
        bus.drain_stall_i = 1'b0;
        step();
        check_eq("first_pop_ready", 64'(bus.in_ready_o), 64'd1);
        check_eq("burst_valid_0", 64'(bus.update_valid_o), 64'd1);
        for (int k = 1; k < 4; k++) begin
            step();
            check_eq($sformatf("burst_valid_%0d", k), 64'(bus.update_valid_o), 64'd1);
        end
        step();
        check_eq("burst_end_valid", 64'(bus.update_valid_o), 64'd0);
        drain("fill");

        // Coalesce: A rewritten in place keeps its slot ahead of B; target LSBs dropped
        bus.drain_stall_i = 1'b1;
        push(32'h1C00A000, 32'h00000100, 1'b1);
        push(32'h1C00B000, 32'h00000200, 1'b1);
        push(32'h1C00A000, 32'h00000302, 1'b1);
        check_eq("coal_count", 64'(bus.count_o), 64'd2);
        expect_upd(32'h1C00A000, 32'h00000300);
        expect_upd(32'h1C00B000, 32'h00000200);
        bus.drain_stall_i = 1'b0;
        drain("coal");

        // Full with a pop in the same cycle: request (even a coalescing one) is refused
        bus.drain_stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(32'h1C004000 + 32'(4 * i), 32'h1C005000 + 32'(16 * i), 1'b1);
            expect_upd(32'h1C004000 + 32'(4 * i), 32'h1C005000 + 32'(16 * i));
        end
        bus.drain_stall_i = 1'b0;
        push(32'h1C004008, 32'hFFFF0000, 1'b1);
        check_eq("fullpop_count", 64'(bus.count_o), 64'd3);
        drain("fullpop");

        // Count of one, head popping while the same PC arrives: new entry allocated
        bus.drain_stall_i = 1'b1;
        push(32'h1C006000, 32'h00000500, 1'b1);
        check_eq("hp_count_pre", 64'(bus.count_o), 64'd1);
        bus.drain_stall_i = 1'b0;
        push(32'h1C006000, 32'h00000600, 1'b1);
        check_eq("hp_count_post", 64'(bus.count_o), 64'd1);
        expect_upd(32'h1C006000, 32'h00000500);
        expect_upd(32'h1C006000, 32'h00000600);
        drain("headpop");

        // Streaming 3*DEPTH updates wraps both pointers several times
        for (int i = 0; i < 3 * DEPTH; i++) begin
            push(32'h1C010000 + 32'(4 * i), 32'h1C020000 + 32'(64 * i), 1'b1);
            expect_upd(32'h1C010000 + 32'(4 * i), 32'h1C020000 + 32'(64 * i));
            if (i == 5) begin
                check_eq("wrap_stream_count", 64'(bus.count_o), 64'd1);
            end
        end
        drain("wrap");

        // Asynchronous reset mid-drain drops the strobe and discards entries at once
        bus.drain_stall_i = 1'b1;
        push(32'h1C007000, 32'h1C008000, 1'b1);
        push(32'h1C007004, 32'h1C008004, 1'b1);
        bus.drain_stall_i = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check_eq("rd_valid", 64'(bus.update_valid_o), 64'd0);
        check_eq("rd_count", 64'(bus.count_o), 64'd0);
        step();
        rst = 1'b1;
        repeat (3) step();
        check_eq("rd_ready", 64'(bus.in_ready_o), 64'd1);
        check_eq("rd_count_after", 64'(bus.count_o), 64'd0);
        check_eq("rd_valid_after", 64'(bus.update_valid_o), 64'd0);
        check_eq("final_leftover", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
